// File: rtl/q2_control.sv
// Q2 microsequencer: fetch/operand/execute sequencing plus front-panel memory operations.
// Every output is registered from the next state, so strobes line up with the state they belong to.
module q2_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       stop,
  input  logic       step,
  input  logic       deposit,
  input  logic       examine,
  input  logic       load_addr,
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       carry,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       rda,
  output logic       wra,
  output logic       rdp,
  output logic       wrp,
  output logic       incp,
  output logic       rdx,
  output logic       wrx,
  output logic [3:0] xin,
  output logic       wrs,
  output logic       dep,
  output logic [1:0] alu_op,
  output logic       halted
);

  typedef enum logic [4:0] {
    StHalt, StFiAcc, StFiLat, StInc1, StFaAcc, StFaLat, StInc2, StExAcc, StExLat, StJmp,
    StLaX, StLaP, StDepAcc, StDepInc, StExmAcc, StExmLat, StExmInc
  } state_e;

  localparam logic [2:0] OpLda = 3'd0;
  localparam logic [2:0] OpSta = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpNor = 3'd3;
  localparam logic [2:0] OpJmp = 3'd4;
  localparam logic [2:0] OpJz  = 3'd5;
  localparam logic [2:0] OpJc  = 3'd6;

  state_e     state_q, state_d, end_st;
  logic       stop_pend_q, stop_pend_d;
  logic       step_mode_q, step_mode_d;
  logic [2:0] op_q, op_d;

  logic       mem_rd_d, mem_wr_d, rda_d, wra_d, rdp_d, wrp_d, incp_d, rdx_d, wrx_d;
  logic [3:0] xin_d;
  logic       wrs_d, dep_d, halted_d;
  logic [1:0] alu_op_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    step_mode_d = step_mode_q;
    stop_pend_d = stop_pend_q | (stop & (state_q != StHalt));
    // Instruction boundary destination; includes a stop arriving in the boundary cycle itself.
    end_st      = (stop_pend_d | step_mode_q) ? StHalt : StFiAcc;
    unique case (state_q)
      StHalt: begin
        if (load_addr)    state_d = StLaX;
        else if (deposit) state_d = StDepAcc;
        else if (examine) state_d = StExmAcc;
        else if (step) begin
          step_mode_d = 1'b1;
          state_d     = StFiAcc;
        end else if (run) state_d = StFiAcc;
      end
      StFiAcc:  if (mem_ready) state_d = StFiLat;
      StFiLat: begin
        op_d    = op;
        state_d = StInc1;
      end
      StInc1:   state_d = StFaAcc;
      StFaAcc:  if (mem_ready) state_d = StFaLat;
      StFaLat:  state_d = StInc2;
      StInc2: begin
        case (op_q)
          OpLda, OpSta, OpAdd, OpNor: state_d = StExAcc;
          OpJmp:   state_d = StJmp;
          OpJz:    state_d = zero ? StJmp : end_st;
          OpJc:    state_d = carry ? StJmp : end_st;
          default: state_d = StHalt;
        endcase
      end
      StExAcc:  if (mem_ready) state_d = (op_q == OpSta) ? end_st : StExLat;
      StExLat:  state_d = end_st;
      StJmp:    state_d = end_st;
      StLaX:    state_d = StLaP;
      StLaP:    state_d = StHalt;
      StDepAcc: if (mem_ready) state_d = StDepInc;
      StDepInc: state_d = StHalt;
      StExmAcc: if (mem_ready) state_d = StExmLat;
      StExmLat: state_d = StExmInc;
      StExmInc: state_d = StHalt;
      default:  state_d = StHalt;
    endcase
    if (state_d == StHalt) begin
      stop_pend_d = 1'b0;
      step_mode_d = 1'b0;
    end
  end

  always_comb begin
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    rda_d    = 1'b0;
    wra_d    = 1'b0;
    rdp_d    = 1'b0;
    wrp_d    = 1'b0;
    incp_d   = 1'b0;
    rdx_d    = 1'b0;
    wrx_d    = 1'b0;
    xin_d    = 4'b0000;
    wrs_d    = 1'b0;
    dep_d    = 1'b0;
    alu_op_d = 2'd0;
    halted_d = 1'b0;
    unique case (state_d)
      StHalt: halted_d = 1'b1;
      StFiAcc, StFiLat, StFaAcc, StExmAcc, StExmLat: begin
        rdp_d    = 1'b1;
        mem_rd_d = 1'b1;
      end
      StFaLat: begin
        rdp_d    = 1'b1;
        mem_rd_d = 1'b1;
        wrx_d    = 1'b1;
        xin_d    = 4'b0001;
      end
      StInc1, StInc2, StDepInc, StExmInc: incp_d = 1'b1;
      StExAcc: begin
        rdx_d    = 1'b1;
        rda_d    = (op_q == OpSta);
        mem_wr_d = (op_q == OpSta);
        mem_rd_d = (op_q != OpSta);
      end
      StExLat: begin
        rdx_d    = 1'b1;
        mem_rd_d = 1'b1;
        wra_d    = 1'b1;
        wrs_d    = (op_q == OpAdd);
        alu_op_d = (op_q == OpAdd) ? 2'd1 : (op_q == OpNor) ? 2'd2 : 2'd0;
      end
      StJmp, StLaP: wrp_d = 1'b1;
      StLaX: begin
        dep_d = 1'b1;
        wrx_d = 1'b1;
        xin_d = 4'b0001;
      end
      StDepAcc: begin
        dep_d    = 1'b1;
        rdp_d    = 1'b1;
        mem_wr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHalt;
      stop_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      op_q        <= 3'd0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      rda         <= 1'b0;
      wra         <= 1'b0;
      rdp         <= 1'b0;
      wrp         <= 1'b0;
      incp        <= 1'b0;
      rdx         <= 1'b0;
      wrx         <= 1'b0;
      xin         <= 4'b0000;
      wrs         <= 1'b0;
      dep         <= 1'b0;
      alu_op      <= 2'd0;
      halted      <= 1'b1;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      step_mode_q <= step_mode_d;
      op_q        <= op_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      rda         <= rda_d;
      wra         <= wra_d;
      rdp         <= rdp_d;
      wrp         <= wrp_d;
      incp        <= incp_d;
      rdx         <= rdx_d;
      wrx         <= wrx_d;
      xin         <= xin_d;
      wrs         <= wrs_d;
      dep         <= dep_d;
      alu_op      <= alu_op_d;
      halted      <= halted_d;
    end
  end

endmodule

// File: tb/tb_q2_control.sv
// Bench for q2_control: directed scenarios with literal expectations, then random stimulus,
// all cross-checked every cycle against a step-list model of the sequencer.
module tb_q2_control;

  logic clk = 1'b0;
  logic rst_n, run, stop, step, deposit, examine, load_addr, zero, carry, mem_ready;
  logic [2:0] op;
  logic mem_rd, mem_wr, rda, wra, rdp, wrp, incp, rdx, wrx, wrs, dep, halted;
  logic [3:0] xin;
  logic [1:0] alu_op;

  q2_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .step(step), .deposit(deposit),
    .examine(examine), .load_addr(load_addr), .op(op), .zero(zero), .carry(carry),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .rda(rda), .wra(wra), .rdp(rdp),
    .wrp(wrp), .incp(incp), .rdx(rdx), .wrx(wrx), .xin(xin), .wrs(wrs), .dep(dep),
    .alu_op(alu_op), .halted(halted)
  );

  always #5 clk = ~clk;

  // Output vector: {mem_rd,mem_wr,rda,wra,rdp,wrp,incp,rdx,wrx,xin[3:0],wrs,dep,alu_op[1:0],halted}
  localparam logic [17:0] MRD = 18'h20000, MWR = 18'h10000, RDA = 18'h08000, WRA = 18'h04000;
  localparam logic [17:0] RDP = 18'h02000, WRP = 18'h01000, INC = 18'h00800, RDX = 18'h00400;
  localparam logic [17:0] WRX = 18'h00200, XDB = 18'h00020, WRS = 18'h00010, DEP = 18'h00008;
  localparam logic [17:0] AADD = 18'h00002, ANOR = 18'h00004, HLTV = 18'h00001;

  logic [17:0] dut_v;
  assign dut_v = {mem_rd, mem_wr, rda, wra, rdp, wrp, incp, rdx, wrx, xin, wrs, dep, alu_op, halted};

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout exp=event at %0t", name, $time);
  endtask

  // Model: each operation is a list of cycles; a list item may wait on mem_ready.
  typedef struct packed {
    logic [17:0] v;
    logic        wt;
    logic        lat;
    logic        dec;
  } step_t;

  step_t q[$];
  logic [17:0] exp_v = HLTV;
  bit stop_pend, step_mode, panel, hlt;
  logic [2:0] op_l;
  step_t cur;

  task automatic push(input logic [17:0] v, input logic wt, input logic lat, input logic dec);
    step_t s;
    s.v = v; s.wt = wt; s.lat = lat; s.dec = dec;
    q.push_back(s);
  endtask

  task automatic push_fetch();
    push(MRD | RDP, 1, 0, 0);
    push(MRD | RDP, 0, 1, 0);
    push(INC, 0, 0, 0);
    push(MRD | RDP, 1, 0, 0);
    push(MRD | RDP | WRX | XDB, 0, 0, 0);
    push(INC, 0, 0, 1);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      stop_pend = 0; step_mode = 0; op_l = 3'd0;
    end else if (q.size() == 0) begin
      panel = 1;
      if (load_addr) begin
        push(DEP | WRX | XDB, 0, 0, 0); push(WRP, 0, 0, 0);
      end else if (deposit) begin
        push(DEP | RDP | MWR, 1, 0, 0); push(INC, 0, 0, 0);
      end else if (examine) begin
        push(RDP | MRD, 1, 0, 0); push(RDP | MRD, 0, 0, 0); push(INC, 0, 0, 0);
      end else if (step) begin
        step_mode = 1; panel = 0; push_fetch();
      end else if (run) begin
        panel = 0; push_fetch();
      end
    end else begin
      if (stop) stop_pend = 1;
      cur = q[0];
      if (!cur.wt || mem_ready) begin
        hlt = 0;
        void'(q.pop_front());
        if (cur.lat) op_l = op;
        if (cur.dec) begin
          case (op_l)
            3'd0: begin push(RDX | MRD, 1, 0, 0); push(RDX | MRD | WRA, 0, 0, 0); end
            3'd1: push(RDX | RDA | MWR, 1, 0, 0);
            3'd2: begin push(RDX | MRD, 1, 0, 0); push(RDX | MRD | WRA | WRS | AADD, 0, 0, 0); end
            3'd3: begin push(RDX | MRD, 1, 0, 0); push(RDX | MRD | WRA | ANOR, 0, 0, 0); end
            3'd4: push(WRP, 0, 0, 0);
            3'd5: if (zero) push(WRP, 0, 0, 0);
            3'd6: if (carry) push(WRP, 0, 0, 0);
            default: hlt = 1;
          endcase
        end
        if (q.size() == 0 && !hlt && !panel && !stop_pend && !step_mode) push_fetch();
      end
      if (q.size() == 0) begin stop_pend = 0; step_mode = 0; end
    end
    exp_v = (q.size() == 0) ? HLTV : q[0].v;
  end

  always @(negedge clk) if (chk_en) chk("cycle", 32'(dut_v), 32'(exp_v));

  int s_cyc, s_wra, s_wrs, s_alu, s_wrp, s_both;

  // Single-step one instruction with the current op/zero/carry and collect its strobes.
  task automatic step_one();
    s_cyc = 0; s_wra = 0; s_wrs = 0; s_alu = 0; s_wrp = 0; s_both = 0;
    step = 1; @(negedge clk); step = 0;
    while (!halted && s_cyc < 60) begin
      s_cyc++;
      if (wra) begin s_wra++; s_wrs = int'(wrs); s_alu = int'(alu_op); end
      if (wrp) s_wrp++;
      if (wrp && incp) s_both++;
      @(negedge clk);
    end
    if (!halted) timeout("step_halt");
  endtask

  int at, hl, ic, cnt;

  initial begin
    rst_n = 0; run = 0; stop = 0; step = 0; deposit = 0; examine = 0; load_addr = 0;
    op = 3'd0; zero = 0; carry = 0; mem_ready = 1;
    @(posedge clk); #1 chk_en = 1;
    @(negedge clk);
    chk("reset_state", 32'(dut_v), 32'(HLTV));
    rst_n = 1;
    @(negedge clk);

    // Free-running LDA stream, then stop during execute of the second instruction.
    run = 1; @(negedge clk); run = 0;
    at = 0; hl = 0; ic = 0;
    for (int i = 1; i <= 14; i++) begin
      if (wra && at == 0) at = i;
      if (halted) hl++;
      if (incp) ic++;
      @(negedge clk);
    end
    chk("lda_latency", 32'(at), 32'd8);
    chk("run_halted_low", 32'(hl), 32'd0);
    chk("run_incp_pairs", 32'(ic), 32'd4);
    stop = 1; @(negedge clk); stop = 0;
    cnt = 0;
    for (int i = 0; i < 30 && !halted; i++) begin
      if (wra) cnt++;
      @(negedge clk);
    end
    chk("stop_wra", 32'(cnt), 32'd1);
    chk("stop_halted", 32'(halted), 32'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_rd) cnt++;
      @(negedge clk);
    end
    chk("stop_no_rd", 32'(cnt), 32'd0);

    // ADD with carry, then conditional jumps.
    op = 3'd2; carry = 1; step_one();
    chk("add_cycles", 32'(s_cyc), 32'd8);
    chk("add_wra", 32'(s_wra), 32'd1);
    chk("add_wrs", 32'(s_wrs), 32'd1);
    chk("add_alu", 32'(s_alu), 32'd1);
    op = 3'd6; step_one();
    chk("jc_cycles", 32'(s_cyc), 32'd7);
    chk("jc_wrp", 32'(s_wrp), 32'd1);
    chk("jc_wrp_incp", 32'(s_both), 32'd0);
    op = 3'd5; zero = 0; step_one();
    chk("jz0_cycles", 32'(s_cyc), 32'd6);
    chk("jz0_wrp", 32'(s_wrp), 32'd0);
    zero = 1; step_one();
    chk("jz1_wrp", 32'(s_wrp), 32'd1);
    op = 3'd1; step_one();
    chk("sta_cycles", 32'(s_cyc), 32'd7);
    op = 3'd7; step_one();
    chk("hlt_cycles", 32'(s_cyc), 32'd6);

    // Operand fetch stalled by mem_ready.
    op = 3'd0;
    step = 1; @(negedge clk); step = 0;
    for (int i = 0; i < 10 && !incp; i++) @(negedge clk);
    if (!incp) timeout("inc1_wait");
    mem_ready = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_rd && rdp && !wrx) cnt++;
    end
    mem_ready = 1;
    @(negedge clk);
    chk("stall_acc_len", 32'(cnt), 32'd4);
    chk("stall_wrx", 32'(wrx), 32'd1);
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    if (!halted) timeout("stall_halt");

    // Reset while waiting on memory.
    mem_ready = 0;
    step = 1; @(negedge clk); step = 0;
    @(negedge clk);
    chk("wait_hold_rd", 32'(mem_rd), 32'd1);
    rst_n = 0; @(negedge clk);
    chk("reset_mid_wait", 32'(dut_v), 32'(HLTV));
    rst_n = 1; mem_ready = 1;
    @(negedge clk);

    // Panel priority and deposit.
    load_addr = 1; deposit = 1; @(negedge clk); load_addr = 0; deposit = 0;
    chk("la_first", 32'(dut_v), 32'h228);
    @(negedge clk);
    chk("la_second", 32'(dut_v), 32'h1000);
    @(negedge clk);
    chk("la_done", 32'(dut_v), 32'(HLTV));
    deposit = 1; @(negedge clk); deposit = 0;
    chk("dep_write", 32'(dut_v), 32'h12008);
    @(negedge clk);
    chk("dep_incp", 32'(dut_v), 32'h800);
    @(negedge clk);
    chk("dep_done", 32'(dut_v), 32'(HLTV));

    // Random traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(299) != 0);
      run       = ($urandom_range(11) == 0);
      step      = ($urandom_range(11) == 0);
      stop      = ($urandom_range(39) == 0);
      deposit   = ($urandom_range(19) == 0);
      examine   = ($urandom_range(19) == 0);
      load_addr = ($urandom_range(19) == 0);
      op        = 3'($urandom);
      zero      = 1'($urandom);
      carry     = 1'($urandom);
      mem_ready = ($urandom_range(3) != 0);
    end
    @(negedge clk);
    run = 0; step = 0; stop = 0; deposit = 0; examine = 0; load_addr = 0; rst_n = 1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
